// File: rtl/switch_pkg.sv
// Shared switch-fabric types: arbiter FSM state encoding and default port count.
package switch_pkg;

    localparam int unsigned N_REQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/port_rr_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
// PORT_ARB_STATS_EN adds the stats_clr / grant_cnt statistics signals.
interface port_rr_arbiter_if
    import switch_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT
);
    localparam int unsigned SEL_W = $clog2(N_REQ);

    logic                 enable;
    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     grant;
    logic [SEL_W-1:0]     mux_select;
    logic                 arb_active;
    logic                 busy;
`ifdef PORT_ARB_STATS_EN
    logic                 stats_clr;
    logic [N_REQ*16-1:0]  grant_cnt;

    modport master (
        output enable, req, stats_clr,
        input  grant, mux_select, arb_active, busy, grant_cnt
    );

    modport slave (
        input  enable, req, stats_clr,
        output grant, mux_select, arb_active, busy, grant_cnt
    );
`else
    modport master (
        output enable, req,
        input  grant, mux_select, arb_active, busy
    );

    modport slave (
        input  enable, req,
        output grant, mux_select, arb_active, busy
    );
`endif

endinterface

// File: rtl/port_rr_arbiter_rr_pick.sv
// Combinational round-robin select: first asserted req at or after last_winner+1, with wrap.
module rr_pick
    import switch_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT,
    localparam int unsigned SEL_W = $clog2(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_winner,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = SEL_W'((32'(last_winner) + i) % N_REQ);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_rr_arbiter.sv
// Per-output-port round-robin arbiter: IDLE -> GRANT (1 cycle) -> XFER (HOLD_CYCLES) -> IDLE.
// PORT_ARB_STATS_EN adds saturating per-requester grant counters with synchronous clear.
module port_rr_arbiter
    import switch_pkg::*;
#(
    parameter int unsigned N_REQ       = N_REQ_DEFAULT,
    parameter int unsigned HOLD_CYCLES = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    port_rr_arbiter_if.slave arb
);
    localparam int unsigned SEL_W = $clog2(N_REQ);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("port_rr_arbiter: HOLD_CYCLES must be in 1..15");
    end
    if (N_REQ < 2) begin : g_bad_nreq
        $error("port_rr_arbiter: N_REQ must be at least 2");
    end

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] winner_q, winner_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] pick;
    logic             pick_valid;
    logic [3:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0] grant;
    logic             arb_active;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req         (arb.req),
        .last_winner (last_q),
        .winner      (pick),
        .any_req     (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            winner_q <= '0;
            last_q   <= SEL_W'(N_REQ - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        grant      = '0;
        arb_active = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb.enable && pick_valid) begin
                    winner_d = pick;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                arb_active      = 1'b1;
                // A winner that withdrew its request aborts without moving the pointer.
                grant[winner_q] = arb.req[winner_q];
                if (arb.req[winner_q]) begin
                    last_d  = winner_q;
                    cnt_d   = 4'(HOLD_CYCLES - 1);
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                arb_active = 1'b1;
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign arb.grant      = grant;
    assign arb.mux_select = winner_q;
    assign arb.arb_active = arb_active;
    assign arb.busy       = (state_q != IDLE);

`ifdef PORT_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (arb.stats_clr) begin
            stat_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant[i] && stat_q[i] != '1) stat_q[i] <= stat_q[i] + 16'd1;
            end
        end
    end

    assign arb.grant_cnt = stat_q;
`endif

endmodule

// File: tb/tb_port_rr_arbiter.sv
// Scoreboard bench for port_rr_arbiter; define PORT_ARB_STATS_EN to also cover the grant counters (HOLD_CYCLES=3).
module tb_port_rr_arbiter;
    import switch_pkg::*;

`ifdef PORT_ARB_STATS_EN
    localparam int HOLD = 3;
`else
    localparam int HOLD = 1;
`endif
    localparam int GAP = HOLD + 2;

    typedef struct {
        logic [3:0] g;
        int         idx;
        int         at;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_g = 0;
    int   arb_run = 0;
    int   last_arb_len = 0;
    exp_t sb[$];

    port_rr_arbiter_if #(.N_REQ(4)) bus ();

    port_rr_arbiter #(.N_REQ(4), .HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_grant(input int idx, input int at, input int gap);
        exp_t e;
        e.g   = 4'b0001 << idx;
        e.idx = idx;
        e.at  = at;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Grant monitor: every observed grant pulse is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            arb_run = 0;
        end else begin
            if (bus.arb_active) arb_run++;
            else if (arb_run != 0) begin
                last_arb_len = arb_run;
                arb_run = 0;
            end
            if (bus.grant != 4'b0000) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", 32'(bus.grant), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("grant", 32'(bus.grant), 32'(e.g));
                    check("mux_select", 32'(bus.mux_select), 32'(e.idx));
                    if (e.at >= 0)  check("grant_latency", cyc, e.at);
                    if (e.gap >= 0) check("grant_gap", cyc - last_g, e.gap);
                end
                last_g = cyc;
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && bus.busy; i++) @(negedge clk);
        check("idle_reached", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.enable = 1'b1;
`ifdef PORT_ARB_STATS_EN
        bus.stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.enable = 1'b1;
`ifdef PORT_ARB_STATS_EN
        bus.stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;

        // Idle after reset with no requests
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_grant", 32'(bus.grant), 32'h0);
            check("idle_active", 32'(bus.arb_active), 32'h0);
            check("idle_busy", 32'(bus.busy), 32'h0);
            check("idle_mux", 32'(bus.mux_select), 32'h0);
        end

        // Single requester held: re-granted after the idle gap
        @(posedge clk);
        #1;
        bus.req = 4'b0100;
        expect_grant(2, cyc + 1, -1);
        expect_grant(2, -1, GAP);
        wait_drain(40);
        check("xfer_busy", 32'(bus.busy), 32'h1);
        bus.req = '0;
        wait_idle(40);
        check("xfer_len", last_arb_len, HOLD + 1);
        check("mux_holds", 32'(bus.mux_select), 32'h2);

        // All requesting: strict rotation from index 0
        apply_reset();
        @(posedge clk);
        #1;
        bus.req = 4'b1111;
        expect_grant(0, cyc + 1, -1);
        expect_grant(1, -1, GAP);
        expect_grant(2, -1, GAP);
        expect_grant(3, -1, GAP);
        expect_grant(0, -1, GAP);
        wait_drain(100);
        bus.req = '0;
        wait_idle(40);

        // Abort: winner drops its request during GRANT
        apply_reset();
        @(posedge clk);
        #1;
        bus.req = 4'b0001;
        @(posedge clk);
        #1;
        bus.req = '0;
        @(negedge clk);
        check("abort_grant", 32'(bus.grant), 32'h0);
        check("abort_active", 32'(bus.arb_active), 32'h1);
        check("abort_mux", 32'(bus.mux_select), 32'h0);
        @(negedge clk);
        check("abort_idle", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        check("abort_len", last_arb_len, 1);
        bus.req = 4'b0011;
        expect_grant(0, cyc + 1, -1);
        expect_grant(1, -1, GAP);
        wait_drain(60);
        bus.req = '0;
        wait_idle(40);

        // enable low blocks arbitration; dropping it mid-transfer does not cut the window
        apply_reset();
        bus.enable = 1'b0;
        bus.req    = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("disabled_busy", 32'(bus.busy), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.enable = 1'b1;
        expect_grant(0, cyc + 1, -1);
        wait_drain(40);
        bus.enable = 1'b0;
        bus.req    = 4'b0010;
        wait_idle(40);
        check("disabled_xfer_len", last_arb_len, HOLD + 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("disabled_hold", 32'(bus.busy), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.req    = '0;
        bus.enable = 1'b1;

        // Reset mid-transfer drops outputs immediately and restores the pointer
        @(posedge clk);
        #1;
        bus.req = 4'b0100;
        expect_grant(2, cyc + 1, -1);
        wait_drain(40);
        bus.req = '0;
        rst_n   = 1'b0;
        #1;
        check("rst_mid_active", 32'(bus.arb_active), 32'h0);
        check("rst_mid_busy", 32'(bus.busy), 32'h0);
        check("rst_mid_mux", 32'(bus.mux_select), 32'h0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bus.req = 4'b1001;
        expect_grant(0, cyc + 1, -1);
        wait_drain(40);
        bus.req = '0;
        wait_idle(40);

`ifdef PORT_ARB_STATS_EN
        // Grant counters: five grants counted, clear wins over the sixth
        apply_reset();
        #1;
        check("cnt_reset", bus.grant_cnt, 64'h0);
        @(posedge clk);
        #1;
        bus.req = 4'b0010;
        expect_grant(1, cyc + 1, -1);
        for (int i = 0; i < 4; i++) expect_grant(1, -1, GAP);
        wait_drain(200);
        check("cnt_five", 32'(bus.grant_cnt[31:16]), 32'd5);
        check("cnt_others", 32'(bus.grant_cnt[15:0]), 32'h0);
        expect_grant(1, -1, GAP);
        repeat (GAP - 1) @(posedge clk);
        #1;
        bus.stats_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.stats_clr = 1'b0;
        bus.req       = '0;
        check("cnt_clear_wins", 32'(bus.grant_cnt[31:16]), 32'h0);
        wait_drain(5);
        wait_idle(40);
        @(posedge clk);
        #1;
        check("cnt_after_clear", 32'(bus.grant_cnt[31:16]), 32'h0);
`endif

        repeat (5) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
